// File: rtl/debug_leds_if.sv
// rtl/debug_leds_if.sv - Wishbone B4 pipelined bus bundle for the debug LED register block
interface wishbone (
    input logic clk_i,
    input logic rst_i
);
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        stall_o;

    modport peripheral (
        input  clk_i, rst_i, cyc_i, stb_i, we_i, adr_i, dat_i,
        output dat_o, ack_o, stall_o
    );

    modport master (
        input  clk_i, rst_i, dat_o, ack_o, stall_o,
        output cyc_i, stb_i, we_i, adr_i, dat_i
    );
endinterface

// File: rtl/debug_leds.sv
// rtl/debug_leds.sv - Wishbone-controlled debug LEDs with write counter and optional blink
// Optional blink logic (BLINK_MASK register, blink counter, blink_phase) enabled by DEBUG_LEDS_BLINK_EN.
module debug_leds #(
    parameter int NUM_LEDS     = 8,
    parameter int BLINK_PERIOD = 50_000_000
) (
    wishbone.peripheral         wb,
    output logic [NUM_LEDS-1:0] leds
);
    localparam logic [1:0] ADR_LED_STATE   = 2'd0;
    localparam logic [1:0] ADR_BLINK_MASK  = 2'd1;
    localparam logic [1:0] ADR_WRITE_COUNT = 2'd2;

    logic                accept;
    logic                wr_en;
    logic [1:0]          adr;
    logic [NUM_LEDS-1:0] led_state;
    logic [NUM_LEDS-1:0] blink_gate;
    logic [NUM_LEDS-1:0] blink_mask_rd;
    logic [15:0]         write_count;
    logic                counted_adr;
    logic                ack_pending;
    logic [31:0]         rd_data;
    logic [31:0]         reg_rdata;
    logic                unused_bits;

    assign adr         = wb.adr_i[1:0];
    assign accept      = wb.cyc_i && wb.stb_i && !wb.rst_i;
    assign wr_en       = accept && wb.we_i;
    assign unused_bits = ^{wb.adr_i[31:2], wb.dat_i};

`ifdef DEBUG_LEDS_BLINK_EN
    localparam int CNT_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

    logic [NUM_LEDS-1:0] blink_mask;
    logic [CNT_W-1:0]    blink_cnt;
    logic                blink_phase;

    always_ff @(posedge wb.clk_i) begin
        if (wb.rst_i) begin
            blink_mask  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (wr_en && adr == ADR_BLINK_MASK)
                blink_mask <= wb.dat_i[NUM_LEDS-1:0];
            if (blink_cnt == CNT_W'(BLINK_PERIOD - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_gate    = blink_mask & {NUM_LEDS{blink_phase}};
    assign blink_mask_rd = blink_mask;
    assign counted_adr   = (adr == ADR_LED_STATE) || (adr == ADR_BLINK_MASK);
`else
    assign blink_gate    = '0;
    assign blink_mask_rd = '0;
    assign counted_adr   = (adr == ADR_LED_STATE);
`endif

    always_comb begin
        reg_rdata = '0;
        case (adr)
            ADR_LED_STATE:   reg_rdata = 32'(led_state);
            ADR_BLINK_MASK:  reg_rdata = 32'(blink_mask_rd);
            ADR_WRITE_COUNT: reg_rdata = {16'h0000, write_count};
            default:         reg_rdata = '0;
        endcase
    end

    // Read data is captured at the accept edge so the ack cycle needs no address.
    always_ff @(posedge wb.clk_i) begin
        if (wb.rst_i) begin
            led_state   <= '0;
            write_count <= '0;
            ack_pending <= 1'b0;
            rd_data     <= '0;
            leds        <= '0;
        end else begin
            ack_pending <= accept;
            rd_data     <= (accept && !wb.we_i) ? reg_rdata : 32'h0;
            if (wr_en && adr == ADR_LED_STATE)
                led_state <= wb.dat_i[NUM_LEDS-1:0];
            if (wr_en && counted_adr && write_count != 16'hFFFF)
                write_count <= write_count + 16'd1;
            leds <= led_state & ~blink_gate;
        end
    end

    // A due ack is dropped when the master has abandoned the cycle or reset hits.
    assign wb.ack_o   = ack_pending && wb.cyc_i && !wb.rst_i;
    assign wb.dat_o   = wb.ack_o ? rd_data : 32'h0;
    assign wb.stall_o = 1'b0;
endmodule

// File: tb/tb_debug_leds.sv
// tb/tb_debug_leds.sv - self-checking bench for debug_leds (vector table plus corner sequences)
module tb_debug_leds;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] leds;

    wishbone wb (.clk_i(clk), .rst_i(rst));

    debug_leds #(.NUM_LEDS(8), .BLINK_PERIOD(4)) dut (
        .wb   (wb),
        .leds (leds)
    );

    always #5 clk = ~clk;

`ifdef DEBUG_LEDS_BLINK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    typedef struct {
        logic        rst, cyc, stb, we;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic        ack;
        logic [31:0] edat;
        logic        lchk;
        logic [7:0]  eleds;
    } vec_t;

    vec_t        vecs[33];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        ack_s;
    logic        stall_s;
    logic [31:0] dat_s;
    logic [7:0]  leds_s;

    function automatic vec_t mk(input logic r, c, s, w, input logic [1:0] a, input logic [31:0] d,
                                input logic k, input logic [31:0] ed, input logic lc, input logic [7:0] el);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.adr = a; v.dat = d;
        v.ack = k; v.edat = ed; v.lchk = lc; v.eleds = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present inputs for one cycle, sample outputs mid-cycle, then advance past the edge.
    task automatic drive(input logic r, c, s, w, input logic [1:0] a, input logic [31:0] d);
        rst = r; wb.cyc_i = c; wb.stb_i = s; wb.we_i = w;
        wb.adr_i = {30'h0, a}; wb.dat_i = d;
        #1;
        ack_s = wb.ack_o; dat_s = wb.dat_o; leds_s = leds; stall_s = wb.stall_o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          ackcnt;
        int          t;
        logic [7:0]  s[24];
        logic [7:0]  other;
        logic [7:0]  exp_l;

        //              rst cyc stb we adr dat            ack edat          lchk leds
        vecs[0]  = mk(1, 1, 1, 1, 0, 32'hFF,        0, 0,            0, 8'h00);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0,             0, 0,            1, 8'h00);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0,             0, 0,            1, 8'h00);
        vecs[3]  = mk(0, 1, 1, 1, 0, 32'hA5,        0, 0,            1, 8'h00);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0,             1, 0,            1, 8'h00);
        vecs[5]  = mk(0, 1, 0, 0, 0, 0,             0, 0,            1, 8'hA5);
        vecs[6]  = mk(0, 1, 1, 0, 2, 0,             0, 0,            1, 8'hA5);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0,             1, 32'h1,        1, 8'hA5);
        vecs[8]  = mk(0, 1, 1, 1, 0, 32'hFFFF_FF0F, 0, 0,            1, 8'hA5);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0,             1, 0,            1, 8'hA5);
        vecs[10] = mk(0, 1, 1, 0, 2, 0,             1, 32'h0F,       1, 8'h0F);
        vecs[11] = mk(0, 1, 0, 0, 0, 0,             1, 32'h2,        1, 8'h0F);
        vecs[12] = mk(0, 1, 1, 1, 0, 32'h3C,        0, 0,            1, 8'h0F);
        vecs[13] = mk(0, 0, 0, 0, 0, 0,             0, 0,            1, 8'h0F);
        vecs[14] = mk(0, 1, 0, 0, 0, 0,             0, 0,            1, 8'h3C);
        vecs[15] = mk(0, 1, 1, 1, 3, 32'h55,        0, 0,            1, 8'h3C);
        vecs[16] = mk(0, 1, 1, 0, 3, 0,             1, 0,            1, 8'h3C);
        vecs[17] = mk(0, 1, 1, 0, 2, 0,             1, 0,            1, 8'h3C);
        vecs[18] = mk(0, 1, 0, 0, 0, 0,             1, 32'h3,        1, 8'h3C);
        vecs[19] = mk(0, 1, 1, 1, 2, 32'h99,        0, 0,            1, 8'h3C);
        vecs[20] = mk(0, 1, 1, 0, 2, 0,             1, 0,            1, 8'h3C);
        vecs[21] = mk(0, 1, 0, 0, 0, 0,             1, 32'h3,        1, 8'h3C);
        vecs[22] = mk(0, 1, 1, 1, 1, 32'h0F,        0, 0,            1, 8'h3C);
        vecs[23] = mk(0, 1, 1, 0, 1, 0,             1, 0,            0, 8'h00);
        vecs[24] = mk(0, 1, 1, 0, 2, 0,             1, BL ? 32'h0F : 32'h0, 0, 8'h00);
        vecs[25] = mk(0, 1, 0, 0, 0, 0,             1, BL ? 32'h4 : 32'h3,  0, 8'h00);
        vecs[26] = mk(0, 1, 1, 1, 0, 32'h77,        0, 0,            0, 8'h00);
        vecs[27] = mk(1, 1, 0, 0, 0, 0,             0, 0,            0, 8'h00);
        vecs[28] = mk(0, 1, 0, 0, 0, 0,             0, 0,            1, 8'h00);
        vecs[29] = mk(0, 1, 1, 0, 0, 0,             0, 0,            1, 8'h00);
        vecs[30] = mk(0, 1, 1, 0, 1, 0,             1, 0,            1, 8'h00);
        vecs[31] = mk(0, 1, 1, 0, 2, 0,             1, 0,            1, 8'h00);
        vecs[32] = mk(0, 1, 0, 0, 0, 0,             1, 0,            1, 8'h00);

        wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0; wb.adr_i = 0; wb.dat_i = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 33; i++) begin
            drive(vecs[i].rst, vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].adr, vecs[i].dat);
            check($sformatf("vec%0d_ack", i), {31'h0, ack_s}, {31'h0, vecs[i].ack});
            check($sformatf("vec%0d_dat", i), dat_s, vecs[i].edat);
            if (vecs[i].lchk)
                check($sformatf("vec%0d_leds", i), {24'h0, leds_s}, {24'h0, vecs[i].eleds});
            if (i == 5)
                check("stall_low", {31'h0, stall_s}, 32'h0);
        end

        // Blink behaviour with LED_STATE=0xFF, BLINK_MASK=0x0F
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 32'hFF);
        drive(0, 1, 1, 1, 1, 32'h0F);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            s[i] = leds_s;
        end
        if (BL) begin
            t = -1;
            for (int i = 1; i < 9; i++)
                if (t < 0 && s[i] != s[i-1]) t = i;
            check("blink_toggle_found", {31'h0, (t >= 0)}, 32'h1);
            if (t >= 0) begin
                check("blink_first_value", {31'h0, (s[t] == 8'hFF || s[t] == 8'hF0)}, 32'h1);
                other = (s[t] == 8'hFF) ? 8'hF0 : 8'hFF;
                for (int j = 0; j < 12; j++) begin
                    exp_l = (((j / 4) % 2) == 0) ? s[t] : other;
                    check($sformatf("blink_seq%0d", j), {24'h0, s[t+j]}, {24'h0, exp_l});
                end
            end
        end else begin
            for (int i = 0; i < 24; i += 5)
                check($sformatf("noblink_leds%0d", i), {24'h0, s[i]}, 32'hFF);
        end

        // WRITE_COUNT saturation
        drive(1, 0, 0, 0, 0, 0);
        ackcnt = 0;
        for (int i = 0; i < 65534; i++) begin
            drive(0, 1, 1, 1, 0, i);
            if (ack_s) ackcnt++;
        end
        check("sat_btb_acks", ackcnt, 65533);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 2, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("count_fffe", dat_s, 32'hFFFE);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 1, 1, 0, 32'h5A);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 2, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("count_sat", dat_s, 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
